// File: rtl/reset_sequencer.sv
// Reset and button conditioning: waits for PLL lock, holds a timed synchronous-release
// reset for downstream logic, and debounces the raw push button.
module reset_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int HOLD_CYCLES     = 16,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic pll_lock,
   input  logic btn_n,
   output logic rst_out_n,
   output logic btn_level,
   output logic btn_press,
   output logic lock_lost
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_HOLD      = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_BTN_HELD  = 2'd3;

   logic [SYNC_STAGES-1:0] lock_sync_r;
   logic [SYNC_STAGES-1:0] btn_sync_r;
   logic                   lock_s;
   logic                   btn_s;

   logic [DB_W-1:0]   db_cnt_r;
   logic [DB_W-1:0]   db_cnt_nx;
   logic              btn_level_nx;
   logic [1:0]        state_r;
   logic [1:0]        state_nx;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_nx;
   logic              lock_lost_nx;

   assign lock_s = lock_sync_r[SYNC_STAGES-1];
   assign btn_s  = btn_sync_r[SYNC_STAGES-1];

   // Synchronizer chains; the button chain resets to "released"
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_sync_r <= '0;
         btn_sync_r  <= '1;
      end else begin
         lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_lock};
         btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btn_n};
      end
   end

   // Debounce: a new level is accepted only after an unbroken run of differing samples
   always_comb begin
      db_cnt_nx    = db_cnt_r;
      btn_level_nx = btn_level;
      if (btn_s == btn_level) begin
         db_cnt_nx = '0;
      end else if (db_cnt_r == DB_LAST) begin
         btn_level_nx = btn_s;
         db_cnt_nx    = '0;
      end else begin
         db_cnt_nx = db_cnt_r + DB_W'(1);
      end
   end

   // Sequencer next-state; lock loss outranks the button in every state
   always_comb begin
      state_nx     = state_r;
      hold_cnt_nx  = hold_cnt_r;
      lock_lost_nx = lock_lost;
      case (state_r)
         ST_WAIT_LOCK: begin
            if (lock_s && btn_level) begin
               state_nx    = ST_HOLD;
               hold_cnt_nx = '0;
            end else begin
               state_nx = ST_WAIT_LOCK;
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               state_nx = ST_WAIT_LOCK;
            end else if (!btn_level) begin
               state_nx = ST_BTN_HELD;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_nx = ST_RUN;
            end else begin
               hold_cnt_nx = hold_cnt_r + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_nx     = ST_WAIT_LOCK;
               lock_lost_nx = 1'b1;
            end else if (!btn_level) begin
               state_nx = ST_BTN_HELD;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_BTN_HELD: begin
            if (!lock_s) begin
               state_nx = ST_WAIT_LOCK;
            end else if (btn_level) begin
               state_nx    = ST_HOLD;
               hold_cnt_nx = '0;
            end else begin
               state_nx = ST_BTN_HELD;
            end
         end
         default: begin
            state_nx    = ST_WAIT_LOCK;
            hold_cnt_nx = '0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_WAIT_LOCK;
         hold_cnt_r <= '0;
         db_cnt_r   <= '0;
         btn_level  <= 1'b1;
         btn_press  <= 1'b0;
         lock_lost  <= 1'b0;
         rst_out_n  <= 1'b0;
      end else begin
         state_r    <= state_nx;
         hold_cnt_r <= hold_cnt_nx;
         db_cnt_r   <= db_cnt_nx;
         btn_level  <= btn_level_nx;
         btn_press  <= btn_level & ~btn_level_nx;
         lock_lost  <= lock_lost_nx;
         rst_out_n  <= (state_nx == ST_RUN);
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: table of steady-state vectors plus
// hand-written sequences for bounce, press/release latency, priority and async reset.
module tb_reset_sequencer;

   logic clk;
   logic rst;
   logic pll_lock;
   logic btn_n;
   logic rst_out_n;
   logic btn_level;
   logic btn_press;
   logic lock_lost;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .SYNC_STAGES    (2),
      .HOLD_CYCLES    (16),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pll_lock (pll_lock),
      .btn_n    (btn_n),
      .rst_out_n(rst_out_n),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .lock_lost(lock_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic lock;
      logic btn;
      int   cycles;
      logic exp_rst;
      logic exp_lvl;
      logic exp_lost;
   } vec_t;

   vec_t  vecs[9];
   string vec_name[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int press_first;
      int press_cnt;
      int level_first;
      int run_first;
      int rst_at10;
      int rst_at11;
      logic lvl_ok;
      logic press_seen;

      // lock, btn, cycles, rst_out_n, btn_level, lock_lost
      vecs[0] = '{1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b0}; vec_name[0] = "idle_nolock";
      vecs[1] = '{1'b1, 1'b1, 18, 1'b0, 1'b1, 1'b0}; vec_name[1] = "lockup_e18";
      vecs[2] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0}; vec_name[2] = "lockup_e19";
      vecs[3] = '{1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b0}; vec_name[3] = "run_steady";
      vecs[4] = '{1'b0, 1'b1,  2, 1'b1, 1'b1, 1'b0}; vec_name[4] = "loss_e2";
      vecs[5] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1}; vec_name[5] = "loss_e3";
      vecs[6] = '{1'b0, 1'b1,  5, 1'b0, 1'b1, 1'b1}; vec_name[6] = "wait_nolock";
      vecs[7] = '{1'b1, 1'b1, 18, 1'b0, 1'b1, 1'b1}; vec_name[7] = "relock_e18";
      vecs[8] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1}; vec_name[8] = "relock_e19";

      rst      = 1'b0;
      pll_lock = 1'b0;
      btn_n    = 1'b1;
      tick(5);
      check("reset_rst_out_n", int'(rst_out_n), 0);
      check("reset_btn_level", int'(btn_level), 1);
      check("reset_lock_lost", int'(lock_lost), 0);
      check("reset_btn_press", int'(btn_press), 0);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         pll_lock = vecs[i].lock;
         btn_n    = vecs[i].btn;
         tick(vecs[i].cycles);
         check({vec_name[i], "_rst_out_n"}, int'(rst_out_n), int'(vecs[i].exp_rst));
         check({vec_name[i], "_btn_level"}, int'(btn_level), int'(vecs[i].exp_lvl));
         check({vec_name[i], "_lock_lost"}, int'(lock_lost), int'(vecs[i].exp_lost));
         check({vec_name[i], "_btn_press"}, int'(btn_press), 0);
      end

      // Bounce: 3-cycle runs never reach the 8-cycle acceptance window
      lvl_ok     = 1'b1;
      press_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         btn_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
         if (btn_level != 1'b1) lvl_ok = 1'b0;
         if (btn_press) press_seen = 1'b1;
      end
      btn_n = 1'b1;
      tick(5);
      check("bounce_level_held", int'(lvl_ok), 1);
      check("bounce_no_press", int'(press_seen), 0);
      check("bounce_still_run", int'(rst_out_n), 1);

      // Stable press: pulse after 10 edges, reset drops one edge later
      press_first = 0;
      press_cnt   = 0;
      rst_at10    = -1;
      rst_at11    = -1;
      btn_n       = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick(1);
         if (btn_press) begin
            press_cnt++;
            if (press_first == 0) press_first = k;
         end
         if (k == 10) rst_at10 = int'(rst_out_n);
         if (k == 11) rst_at11 = int'(rst_out_n);
      end
      check("press_edge", press_first, 10);
      check("press_single_pulse", press_cnt, 1);
      check("press_rst_before", rst_at10, 1);
      check("press_rst_after", rst_at11, 0);
      check("press_level", int'(btn_level), 0);

      // Release from BTN_HELD: level at edge 10, full hold, run at edge 27
      level_first = 0;
      run_first   = 0;
      press_cnt   = 0;
      btn_n       = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         if (btn_level && level_first == 0) level_first = k;
         if (rst_out_n && run_first == 0) run_first = k;
         if (btn_press) press_cnt++;
      end
      check("release_level_edge", level_first, 10);
      check("release_run_edge", run_first, 27);
      check("release_no_press", press_cnt, 0);
      check("release_lock_lost", int'(lock_lost), 1);

      // Async reset in the middle of HOLD clears the sticky flag at once
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      tick(10);
      check("midhold_rst_out_n", int'(rst_out_n), 0);
      rst = 1'b0;
      #1;
      check("async_rst_lock_lost", int'(lock_lost), 0);
      check("async_rst_rst_out_n", int'(rst_out_n), 0);
      check("async_rst_btn_level", int'(btn_level), 1);
      check("async_rst_btn_press", int'(btn_press), 0);
      tick(2);
      rst = 1'b1;
      tick(18);
      check("postrst_lockup_e18", int'(rst_out_n), 0);
      tick(1);
      check("postrst_lockup_e19", int'(rst_out_n), 1);
      check("postrst_lock_lost", int'(lock_lost), 0);

      // Lock drop and debounced press seen by the sequencer in the same cycle
      btn_n = 1'b0;
      tick(8);
      pll_lock = 1'b0;
      tick(2);
      check("simul_pre_rst_out_n", int'(rst_out_n), 1);
      check("simul_pre_btn_level", int'(btn_level), 0);
      check("simul_pre_btn_press", int'(btn_press), 1);
      check("simul_pre_lock_lost", int'(lock_lost), 0);
      tick(1);
      check("simul_rst_out_n", int'(rst_out_n), 0);
      check("simul_lock_lost", int'(lock_lost), 1);
      check("simul_btn_press", int'(btn_press), 0);
      pll_lock = 1'b1;
      tick(25);
      check("simul_wait_btn_held", int'(rst_out_n), 0);
      check("simul_lost_sticky", int'(lock_lost), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset and button-conditioning stage sitting directly upstream of the LED counter logic on the GateMate board designs. Runs on the PLL output clock, waits for the PLL lock, holds a clean synchronous-release reset for a programmable number of cycles, and debounces the raw user push button. Downstream counters use `rst_out_n` instead of the raw board reset, so they never run on an unlocked clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `pll_lock` and `btn_n` (≥2).
- `HOLD_CYCLES`, 16: cycles `rst_out_n` stays low after lock is seen (≥1).
- `DEBOUNCE_CYCLES`, 1000000: cycles of stable synchronized button before the level is accepted (≥1; 10 ms at 100 MHz).

- `clk`  in  1  PLL output clock (CLK0); single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `pll_lock`  in  1  PLL locked indication; asynchronous to `clk`.
- `btn_n`  in  1  raw push button, active-low; asynchronous and bouncy.
- `rst_out_n`  out  1  active-low reset to downstream logic; synchronous deassert.
- `btn_level`  out  1  debounced button level (1 = released).
- `btn_press`  out  1  one-cycle pulse on debounced press.
- `lock_lost`  out  1  sticky flag: lock dropped while in RUN.

## Operation
- Reset (`rst`=0, asynchronous): state=WAIT_LOCK, all synchronizer flops 0 for lock and 1 for button, `rst_out_n`=0, `btn_level`=1, `btn_press`=0, `lock_lost`=0, counters 0.
- Synchronizers: `pll_lock` → `lock_s`, `btn_n` → `btn_s`, each SYNC_STAGES flops.
- Debouncer: `db_cnt` width max(1, clog2(DEBOUNCE_CYCLES)). If `btn_s`==`btn_level`: `db_cnt`←0. Else if `db_cnt`==DEBOUNCE_CYCLES-1: `btn_level`←`btn_s`, `db_cnt`←0. Else `db_cnt`+1. Any bounce back to `btn_level` restarts the count.
- `btn_press`←1 on exactly the edge where `btn_level` goes 1→0, else 0. No pulse on release.
- FSM, priority top-down per state:
  - WAIT_LOCK: `lock_s`=1 and `btn_level`=1 → HOLD (`hold_cnt`←0).
  - HOLD: `lock_s`=0 → WAIT_LOCK; `btn_level`=0 → BTN_HELD; `hold_cnt`==HOLD_CYCLES-1 → RUN; else `hold_cnt`+1.
  - RUN: `lock_s`=0 → WAIT_LOCK and `lock_lost`←1; `btn_level`=0 → BTN_HELD.
  - BTN_HELD: `lock_s`=0 → WAIT_LOCK; `btn_level`=1 → HOLD (`hold_cnt`←0).
- `rst_out_n` is a flop loaded with (next state == RUN); it is 1 only while in RUN.
- `lock_lost` cleared only by `rst`.

## Timing
- Lock-up latency: `pll_lock` sampled high at edge 0 → `lock_s` high after SYNC_STAGES edges → HOLD one edge later → `rst_out_n` rises SYNC_STAGES+1+HOLD_CYCLES edges after edge 0 (19 with defaults).
- Lock-loss latency: `pll_lock` sampled low → `rst_out_n` falls and `lock_lost` sets SYNC_STAGES+1 edges later (3 with defaults).
- Button: `btn_n` stable low from edge 0 → `btn_level` falls and `btn_press` pulses at edge SYNC_STAGES+DEBOUNCE_CYCLES; `rst_out_n` falls one edge later.
- Release in BTN_HELD re-runs the full HOLD_CYCLES before `rst_out_n` rises.
- Lock drop and button press in the same cycle: lock wins (WAIT_LOCK).
- Lock glitch shorter than one `clk` period may be missed; no requirement to catch it.
- `rst` asserted mid-HOLD or mid-RUN: immediate return to reset values, `lock_lost` cleared.

## Test plan
- Use SYNC_STAGES=2, HOLD_CYCLES=16, DEBOUNCE_CYCLES=8 unless stated.
- Power-up: `rst` low 5 cycles, `pll_lock`=0 → `rst_out_n`=0, `btn_level`=1, `lock_lost`=0; raise `pll_lock` → `rst_out_n` rises exactly 19 edges later.
- Lock loss in RUN: drop `pll_lock` → `rst_out_n`=0 and `lock_lost`=1 after 3 edges; restore lock → `rst_out_n` back high 19 edges later, `lock_lost` stays 1.
- Bounce: toggle `btn_n` low/high every 3 cycles for 40 cycles → `btn_level` stays 1, no `btn_press`; then hold low → `btn_press` single pulse 10 edges after last transition, `rst_out_n` low next edge.
- Release: from BTN_HELD release button for 8+2 cycles → `btn_level`=1, `rst_out_n` high 16 edges later; no pulse on release.
- Simultaneous: drop `pll_lock` and debounced press land same cycle → state WAIT_LOCK, `lock_lost`=1; assert `rst` mid-HOLD (cycle 8) → outputs return to reset values immediately.
